fetch_sequencer: RTL and testbench

- Sequences the combinational instruction memory for the CPU pipeline.
- Owns the PC and drives the word address into instruction memory each cycle.
- Buffers fetched words in a small FIFO so a stalled decode stage never loses an instruction, and applies branch redirects with flush.
- Detects end of program: an all-zero word is the instruction memory's default for unmapped addresses.

---
 rtl/fetch_sequencer_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_sequencer.sv | 70 +++++++
 tb/tb_fetch_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared width, step, zero word and FSM encoding for the fetch sequencer
package fetch_sequencer_pkg;
    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] PC_STEP = 4;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
    typedef enum logic [1:0] {FS_RUN = 2'd0, FS_DRAIN = 2'd1, FS_DONE = 2'd2} fs_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular fetch buffer with flush; head reads as zero while empty
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = DEPTH[AW:0];
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == CAP;
    assign do_pop = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign head = empty ? '0 : mem[rd_ptr];
    // pointers and occupancy; a flush discards everything, including a same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    // storage needs no reset because head is masked while the buffer is empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches from combinational imem into a buffer, handles redirects and end of program
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = 2,
    parameter bit END_ON_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic [WORD_WIDTH-1:0] imem_instr,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_target,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [WORD_WIDTH-1:0] if_instr,
    output logic [WORD_WIDTH-1:0] if_pc,
    output logic                  done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fs_state_e state, state_nxt;
    logic [WORD_WIDTH-1:0] pc, pc_nxt;
    logic [2*WORD_WIDTH-1:0] head;
    logic [CW-1:0] count;
    logic full, empty, pop, fetch, zero, push, last_pop, unused_low;
    assign imem_addr = {2'b00, pc[WORD_WIDTH-1:2]};
    assign if_valid = !empty;
    assign {if_pc, if_instr} = head;
    assign done = state == FS_DONE;
    assign pop = if_valid && if_ready;
    assign last_pop = pop && count == CW'(1);
    assign zero = END_ON_ZERO && imem_instr == ZERO_WORD;
    assign fetch = state == FS_RUN && !freeze && !branch_taken && (!full || pop);
    assign push = fetch && !zero;
    assign unused_low = ^branch_target[1:0];

    fetch_fifo #(.WIDTH(2 * WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .flush(branch_taken),
        .din({pc, imem_instr}),
        .head(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    // redirect wins; a drained buffer finishes the program; a zero word stops fetching
    always_comb begin
        state_nxt = branch_taken ? FS_RUN
                  : (state == FS_DRAIN && (empty || last_pop)) ? FS_DONE
                  : (fetch && zero) ? FS_DRAIN : state;
        pc_nxt = branch_taken ? {branch_target[WORD_WIDTH-1:2], 2'b00} : push ? pc + PC_STEP : pc;
    end

    // PC and FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FS_RUN;
            pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: queue-based reference model plus directed scenarios for the fetch sequencer
module tb_fetch_sequencer;
    localparam int W = 32;
    localparam int DEPTH = 2;
    logic clk = 1'b0, rst_n = 1'b1, freeze = 1'b0, branch_taken = 1'b0, if_ready = 1'b1;
    logic [W-1:0] branch_target = '0;
    logic [W-1:0] imem_instr, imem_addr, if_instr, if_pc;
    logic if_valid, done;
    logic [W-1:0] mem [32];
    int compared = 0, mismatched = 0;
    logic [2*W-1:0] mq [$];
    logic [W-1:0] mpc = '0;
    int mst = 0;
    bit popped, room;

    fetch_sequencer #(.RESET_PC('0), .FIFO_DEPTH(DEPTH), .END_ON_ZERO(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .freeze(freeze),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_instr(if_instr),
        .if_pc(if_pc),
        .done(done)
    );

    always #5 clk = ~clk;

    assign imem_instr = imem_addr < 32 ? mem[imem_addr[4:0]] : '0;

    function automatic logic [W-1:0] word_at(logic [W-1:0] a);
        return (a >> 2) < 32 ? mem[a[6:2]] : '0;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // reference model: buffer as a queue, state as 0 running / 1 draining / 2 finished
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            mpc = '0;
            mst = 0;
        end else if (branch_taken) begin
            mq.delete();
            mpc = branch_target & ~32'h3;
            mst = 0;
        end else begin
            popped = mq.size() > 0 && if_ready;
            room = mq.size() < DEPTH || popped;
            if (popped) void'(mq.pop_front());
            if (mst == 1) begin
                if (mq.size() == 0) mst = 2;
            end else if (mst == 0 && !freeze && room) begin
                if (word_at(mpc) == '0) mst = 1;
                else begin
                    mq.push_back({mpc, word_at(mpc)});
                    mpc = mpc + 4;
                end
            end
        end
    end

    // every-cycle comparison against the model, mid-cycle
    initial forever begin
        @(negedge clk);
        chk("valid", W'(if_valid), W'(mq.size() > 0));
        chk("done", W'(done), W'(mst == 2));
        chk("imem_addr", imem_addr, mpc >> 2);
        if (mq.size() > 0) begin
            chk("if_pc", if_pc, mq[0][2*W-1:W]);
            chk("if_instr", if_instr, mq[0][W-1:0]);
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hE280_0000 + W'(i);
        mem[0] = 32'hE3A00014;
        mem[1] = 32'hE3A01A01;
        mem[18] = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", W'(if_valid), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_addr", imem_addr, '0);
        chk("rst_pc", if_pc, '0);
        chk("rst_instr", if_instr, '0);
        #9 rst_n = 1'b1;
        step(1);
        chk("c1_pc", if_pc, 32'h0);
        chk("c1_instr", if_instr, 32'hE3A00014);
        step(1);
        chk("c2_pc", if_pc, 32'h4);
        chk("c2_instr", if_instr, 32'hE3A01A01);
        step(4);
        branch_taken = 1'b1;
        branch_target = 32'h0;
        step(1);
        branch_taken = 1'b0;
        chk("restart_flush", W'(if_valid), '0);
        step(1);
        chk("restart_pc", if_pc, 32'h0);
        if_ready = 1'b0;
        step(5);
        chk("stall_valid", W'(if_valid), 32'h1);
        chk("stall_addr", imem_addr, 32'h2);
        chk("stall_instr", if_instr, 32'hE3A00014);
        if_ready = 1'b1;
        chk("rel_pc0", if_pc, 32'h0);
        step(1);
        chk("rel_pc4", if_pc, 32'h4);
        step(1);
        chk("rel_pc8", if_pc, 32'h8);
        branch_taken = 1'b1;
        branch_target = 32'h3D;
        step(1);
        branch_taken = 1'b0;
        chk("br_squash", W'(if_valid), '0);
        step(1);
        chk("br_pc", if_pc, 32'h3C);
        chk("br_instr", if_instr, 32'hE280000F);
        step(4);
        chk("end_done", W'(done), 32'h1);
        chk("end_valid", W'(if_valid), '0);
        chk("end_addr", imem_addr, 32'd18);
        branch_taken = 1'b1;
        branch_target = 32'h0;
        step(1);
        branch_taken = 1'b0;
        chk("rebr_done", W'(done), '0);
        step(1);
        chk("rebr_instr", if_instr, 32'hE3A00014);
        if_ready = 1'b0;
        step(1);
        freeze = 1'b1;
        if_ready = 1'b1;
        step(3);
        chk("frz_valid", W'(if_valid), '0);
        chk("frz_addr", imem_addr, 32'h2);
        freeze = 1'b0;
        step(1);
        chk("frz_resume", if_pc, 32'h8);
        if_ready = 1'b0;
        step(1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", W'(if_valid), '0);
        chk("arst_addr", imem_addr, '0);
        chk("arst_done", W'(done), '0);
        #3 rst_n = 1'b1;
        if_ready = 1'b1;
        step(1);
        chk("arst_pc0", if_pc, 32'h0);
        chk("arst_instr", if_instr, 32'hE3A00014);
        step(1);
        chk("arst_pc4", if_pc, 32'h4);
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
